// File: rtl/can_core_sequencer_if.sv
// Host link stream bundle for the CanCore job sequencer.
//
// Ports (modports):
//   master : host side   - drives in_valid/in_data and out_ready
//   slave  : sequencer   - drives in_ready and out_valid/out_data
//
// Handshake: a beat moves on a rising clock edge where valid and ready are
// both 1. The source holds data stable and keeps valid high until that edge.
// The sink may raise or drop ready freely. Neither side may wait for the other
// before asserting its own signal.
interface can_core_sequencer_if #(
  parameter int BEAT_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [BEAT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/can_core_sequencer.sv
// Host-side job sequencer for CanCore.
// The sequencer runs one job at a time:
//   1. It loads the program image, one 20-bit word per host beat.
//   2. It loads the data image, one 512-bit word per 16 host beats.
//   3. It pulses the core reset, then pulses io_take.
//   4. It waits for io_halted.
//   5. It streams a window of data memory back to the host, low beat first.
//
// Ports:
//   clock, reset           clock and synchronous active-high reset
//   io_start               job start pulse; latches io_progWords/io_dataWords/
//                          io_dumpBase/io_dumpWords; ignored unless idle
//   io                     host stream bundle (slave side)
//   io_busy / io_done      job in progress / one-cycle end-of-job pulse
//   io_error               sticky run timeout flag
//   core_reset, core_take  CanCore reset and io_take
//   core_halted            CanCore io_halted
//   pm_write_*             programMemory write port
//   dm_write_*             dataMemory write port
//   dm_read_addr/data      dataMemory read port, data one cycle after address
//   dbgState               current FSM state
//
// Optional feature, controlled by the macro CAN_SEQ_TIMEOUT_EN:
//   When the macro is defined, RUN gives up after TIMEOUT cycles without halted.
//   It then sets io_error and goes to DONE without dumping.
module can_core_sequencer #(
  parameter int BEAT_W  = 32,
  parameter int PM_AW   = 7,
  parameter int PM_DW   = 20,
  parameter int DM_AW   = 4,
  parameter int DM_DW   = 512,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_start,
  input  logic [PM_AW:0]         io_progWords,
  input  logic [DM_AW:0]         io_dataWords,
  input  logic [DM_AW-1:0]       io_dumpBase,
  input  logic [DM_AW:0]         io_dumpWords,
  can_core_sequencer_if.slave    io,
  output logic                   io_busy,
  output logic                   io_done,
  output logic                   io_error,
  output logic                   core_reset,
  output logic                   core_take,
  input  logic                   core_halted,
  output logic                   pm_write_en,
  output logic [PM_AW-1:0]       pm_write_addr,
  output logic [PM_DW-1:0]       pm_write_data,
  output logic                   dm_write_en,
  output logic [DM_AW-1:0]       dm_write_addr,
  output logic [DM_DW-1:0]       dm_write_data,
  output logic [DM_AW-1:0]       dm_read_addr,
  input  logic [DM_DW-1:0]       dm_read_data,
  output logic [3:0]             dbgState
);

  localparam int BEATS = DM_DW / BEAT_W;
  localparam int BW    = $clog2(BEATS);
  // One counter serves program words, data words and dump words.
  // It is sized for the largest of these counts.
  localparam int CW    = PM_AW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD_PROG = 4'd1,
    LOAD_DATA = 4'd2,
    WRITE_DM  = 4'd3,
    CLEAR     = 4'd4,
    START     = 4'd5,
    RUN       = 4'd6,
    DUMP_RD   = 4'd7,
    DUMP_CAP  = 4'd8,
    DUMP_TX   = 4'd9,
    DONE      = 4'd10
  } seqState_e;

  seqState_e        state;
  logic [PM_AW:0]   progWordsQ;
  logic [DM_AW:0]   dataWordsQ;
  logic [DM_AW-1:0] dumpBaseQ;
  logic [DM_AW:0]   dumpWordsQ;
  logic [CW-1:0]    wordCnt;
  logic [BW-1:0]    beatCnt;
  logic [DM_DW-1:0] dataWord;
  logic [DM_DW-1:0] outWord;
  logic             outValidQ;
`ifdef CAN_SEQ_TIMEOUT_EN
  logic [31:0]      runCnt;
  logic             errorQ;
`endif

  // The status and core-control outputs are pure decodes of the state register.
  // They change only on the clock edge.
  assign io_busy    = (state != IDLE) && (state != DONE);
  assign io_done    = (state == DONE);
  assign core_reset = (state == IDLE) || (state == CLEAR);
  assign core_take  = (state == START);
  assign dbgState   = state;

  // in_ready is low during the WRITE_DM cycle.
  // That cycle commits the assembled word to data memory.
  assign io.in_ready  = (state == LOAD_PROG) || (state == LOAD_DATA);
  assign io.out_valid = outValidQ;
  assign io.out_data  = outWord[beatCnt*BEAT_W +: BEAT_W];

  // A program beat is written in the same cycle it is accepted.
  assign pm_write_en   = (state == LOAD_PROG) && io.in_valid;
  assign pm_write_addr = wordCnt[PM_AW-1:0];
  assign pm_write_data = io.in_data[PM_DW-1:0];

  assign dm_write_en   = (state == WRITE_DM);
  assign dm_write_addr = wordCnt[DM_AW-1:0];
  assign dm_write_data = dataWord;

  // The dump window is DM_AW bits wide, so an address past the top of data
  // memory wraps to address 0.
  assign dm_read_addr  = dumpBaseQ + wordCnt[DM_AW-1:0];

`ifdef CAN_SEQ_TIMEOUT_EN
  assign io_error = errorQ;
`else
  assign io_error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      progWordsQ <= '0;
      dataWordsQ <= '0;
      dumpBaseQ  <= '0;
      dumpWordsQ <= '0;
      wordCnt    <= '0;
      beatCnt    <= '0;
      dataWord   <= '0;
      outWord    <= '0;
      outValidQ  <= 1'b0;
`ifdef CAN_SEQ_TIMEOUT_EN
      runCnt     <= '0;
      errorQ     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (io_start) begin
            progWordsQ <= io_progWords;
            dataWordsQ <= io_dataWords;
            dumpBaseQ  <= io_dumpBase;
            dumpWordsQ <= io_dumpWords;
            wordCnt    <= '0;
            beatCnt    <= '0;
`ifdef CAN_SEQ_TIMEOUT_EN
            errorQ     <= 1'b0;
`endif
            if (io_progWords != '0)      state <= LOAD_PROG;
            else if (io_dataWords != '0) state <= LOAD_DATA;
            else                         state <= CLEAR;
          end
        end
        LOAD_PROG: begin
          if (io.in_valid) begin
            if (wordCnt + ONE == progWordsQ) begin
              wordCnt <= '0;
              state   <= (dataWordsQ != '0) ? LOAD_DATA : CLEAR;
            end else begin
              wordCnt <= wordCnt + ONE;
            end
          end
        end
        LOAD_DATA: begin
          if (io.in_valid) begin
            dataWord[beatCnt*BEAT_W +: BEAT_W] <= io.in_data;
            if (beatCnt == LAST_BEAT) begin
              beatCnt <= '0;
              state   <= WRITE_DM;
            end else begin
              beatCnt <= beatCnt + 1'b1;
            end
          end
        end
        WRITE_DM: begin
          if (wordCnt + ONE == CW'(dataWordsQ)) begin
            wordCnt <= '0;
            state   <= CLEAR;
          end else begin
            wordCnt <= wordCnt + ONE;
            state   <= LOAD_DATA;
          end
        end
        // This one-cycle core reset clears any halted flag left over from an
        // earlier job.
        CLEAR: state <= START;
        START: begin
`ifdef CAN_SEQ_TIMEOUT_EN
          runCnt <= '0;
`endif
          state <= RUN;
        end
        RUN: begin
          if (core_halted) begin
            state <= (dumpWordsQ != '0) ? DUMP_RD : DONE;
`ifdef CAN_SEQ_TIMEOUT_EN
          end else if (runCnt == 32'(TIMEOUT - 1)) begin
            errorQ <= 1'b1;
            state  <= DONE;
          end else begin
            runCnt <= runCnt + 32'd1;
`endif
          end
        end
        // Memory samples dm_read_addr at the end of DUMP_RD.
        // The read data is then valid throughout DUMP_CAP.
        DUMP_RD: state <= DUMP_CAP;
        DUMP_CAP: begin
          outWord   <= dm_read_data;
          outValidQ <= 1'b1;
          beatCnt   <= '0;
          state     <= DUMP_TX;
        end
        DUMP_TX: begin
          if (io.out_ready) begin
            if (beatCnt == LAST_BEAT) begin
              beatCnt   <= '0;
              outValidQ <= 1'b0;
              if (wordCnt + ONE == CW'(dumpWordsQ)) begin
                wordCnt <= '0;
                state   <= DONE;
              end else begin
                wordCnt <= wordCnt + ONE;
                state   <= DUMP_RD;
              end
            end else begin
              beatCnt <= beatCnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
